// File: rtl/psum_xchg_pkg.sv
// Shared types, default widths and arithmetic helpers for the partial-sum exchange ring.
package psum_xchg_pkg;

  localparam int DEF_N_CORE = 4;
  localparam int DEF_BW_SUM = 24;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_PTR_W  = 3;

  typedef enum logic [1:0] {
    XCHG_IDLE   = 2'd0,
    XCHG_GATHER = 2'd1,
    XCHG_RESULT = 2'd2
  } xchg_state_e;

  // Clamp a signed value into the two's-complement range of a bw-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int bw);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (bw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (bw - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

  function automatic int ring_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/psum_link_fifo.sv
// Single-writer first-word-fall-through link FIFO with full/empty flags and a
// sticky flag recording any write dropped because the link was full.
module psum_link_fifo
  import psum_xchg_pkg::*;
#(
  parameter int BW    = DEF_BW_SUM,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_data,
  input  logic          rd_en,
  output logic [BW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [BW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // A pop frees a slot in the same cycle, so a write on a full link is still taken when popped.
  always_comb begin
    rd_ok_s  = rd_en & ~empty_q;
    wr_ok_s  = wr_en & (~full_q | rd_ok_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d     = (count_d == DEPTH_C);
    empty_d    = (count_d == CNT_W'(0));
    overflow_d = overflow_q | (wr_en & ~wr_ok_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the head is only consumed when the link is non-empty.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/psum_exchange_ring.sv
// N-core partial-sum interconnect: ring pass of link heads to the successor core,
// or a saturating all-reduce broadcast back to every core.
module psum_exchange_ring
  import psum_xchg_pkg::*;
#(
  parameter int N_CORE = DEF_N_CORE,
  parameter int BW_SUM = DEF_BW_SUM,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = DEF_PTR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CORE*BW_SUM-1:0] sum_out,
  input  logic [N_CORE-1:0]        fifo_wr,
  input  logic [N_CORE-1:0]        fifo_rd,
  input  logic                     mode,
  input  logic                     start,
  output logic [N_CORE*BW_SUM-1:0] sum_in,
  output logic [N_CORE-1:0]        sum_valid,
  output logic [N_CORE-1:0]        link_full,
  output logic [N_CORE-1:0]        link_empty,
  output logic [N_CORE-1:0]        overflow,
  output logic                     done
);

  localparam int ACC_W = BW_SUM + $clog2(N_CORE);

  xchg_state_e              state_q, state_d;
  logic                     mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [N_CORE-1:0]        res_valid_q, res_valid_d;
  logic                     done_q, done_d;

  logic [N_CORE-1:0]        link_rd_s;
  logic [N_CORE-1:0]        link_full_s;
  logic [N_CORE-1:0]        link_empty_s;
  logic [N_CORE-1:0]        link_ovf_s;
  logic [BW_SUM-1:0]        head_s [N_CORE];
  logic signed [ACC_W-1:0]  chain_s [N_CORE+1];
  logic [N_CORE-1:0]        ring_rd_s;
  logic [N_CORE-1:0]        ring_valid_s;
  logic [N_CORE*BW_SUM-1:0] ring_data_s;
  logic [BW_SUM-1:0]        sat_s;
  logic [N_CORE*BW_SUM-1:0] sum_in_s;
  logic [N_CORE-1:0]        sum_valid_s;

  assign chain_s[0] = '0;

  // Link g is written by core g and drained by its ring successor NXT.
  for (genvar g = 0; g < N_CORE; g++) begin : g_link
    localparam int NXT = ring_next(g, N_CORE);

    psum_link_fifo #(
      .BW    (BW_SUM),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (fifo_wr[g]),
      .wr_data  (sum_out[g*BW_SUM +: BW_SUM]),
      .rd_en    (link_rd_s[g]),
      .rd_data  (head_s[g]),
      .full     (link_full_s[g]),
      .empty    (link_empty_s[g]),
      .overflow (link_ovf_s[g])
    );

    assign ring_rd_s[g]                       = fifo_rd[NXT];
    assign ring_valid_s[NXT]                  = ~link_empty_s[g];
    assign ring_data_s[NXT*BW_SUM +: BW_SUM]  = link_empty_s[g] ? '0 : head_s[g];
    assign chain_s[g+1] = chain_s[g] + {{(ACC_W-BW_SUM){head_s[g][BW_SUM-1]}}, head_s[g]};
  end

  assign sat_s = BW_SUM'(sat_to_width(64'(acc_q), BW_SUM));

  // Reduction control: gather one head per link, then hold the result until every core acks.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;
    link_rd_s   = '0;
    case (state_q)
      XCHG_IDLE: begin
        link_rd_s = mode_q ? '0 : ring_rd_s;
        if (start && mode) begin
          mode_d  = 1'b1;
          state_d = XCHG_GATHER;
        end else begin
          mode_d  = 1'b0;
        end
      end
      XCHG_GATHER: begin
        if (link_empty_s == '0) begin
          link_rd_s   = '1;
          acc_d       = chain_s[N_CORE];
          res_valid_d = '1;
          state_d     = XCHG_RESULT;
        end else begin
          link_rd_s   = '0;
        end
      end
      XCHG_RESULT: begin
        res_valid_d = res_valid_q & ~fifo_rd;
        if (res_valid_d == '0) begin
          done_d  = 1'b1;
          mode_d  = 1'b0;
          state_d = XCHG_IDLE;
        end else begin
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d     = XCHG_IDLE;
        mode_d      = 1'b0;
        res_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= XCHG_IDLE;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      res_valid_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  // Delivery mux: ring heads while idle, the broadcast result while reporting.
  always_comb begin
    sum_in_s    = '0;
    sum_valid_s = '0;
    case (state_q)
      XCHG_IDLE: begin
        sum_in_s    = ring_data_s;
        sum_valid_s = ring_valid_s;
      end
      XCHG_RESULT: begin
        sum_in_s    = {N_CORE{sat_s}};
        sum_valid_s = res_valid_q;
      end
      default: begin
        sum_in_s    = '0;
        sum_valid_s = '0;
      end
    endcase
  end

  assign sum_in     = sum_in_s;
  assign sum_valid  = sum_valid_s;
  assign link_full  = link_full_s;
  assign link_empty = link_empty_s;
  assign overflow   = link_ovf_s;
  assign done       = done_q;

endmodule

// File: tb/tb_psum_exchange_ring.sv
// Self-checking bench for psum_exchange_ring: ring-pass and all-reduce tables plus
// hand sequences for link overflow, gather stalls and reset mid-result (N=4 and N=2).
module tb_psum_exchange_ring;

  logic        clk = 1'b0;
  logic        reset;
  logic [95:0] sum_out;
  logic [3:0]  fifo_wr, fifo_rd;
  logic        mode, start;
  logic [95:0] sum_in;
  logic [3:0]  sum_valid, link_full, link_empty, overflow;
  logic        done;

  logic [47:0] sum_out2;
  logic [1:0]  fifo_wr2, fifo_rd2;
  logic        mode2, start2;
  logic [47:0] sum_in2;
  logic [1:0]  sum_valid2, link_full2, link_empty2, overflow2;
  logic        done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] sb_q [4][$];
  logic [23:0] res_q [$];

  always #5 clk = ~clk;

  psum_exchange_ring u_dut (
    .clk(clk), .reset(reset), .sum_out(sum_out), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .mode(mode), .start(start), .sum_in(sum_in), .sum_valid(sum_valid),
    .link_full(link_full), .link_empty(link_empty), .overflow(overflow), .done(done)
  );

  psum_exchange_ring #(.N_CORE(2)) u_dut2 (
    .clk(clk), .reset(reset), .sum_out(sum_out2), .fifo_wr(fifo_wr2), .fifo_rd(fifo_rd2),
    .mode(mode2), .start(start2), .sum_in(sum_in2), .sum_valid(sum_valid2),
    .link_full(link_full2), .link_empty(link_empty2), .overflow(overflow2), .done(done2)
  );

  typedef struct {
    logic [3:0]  wr;
    logic [3:0]  rd;
    logic [23:0] base;
    logic [3:0]  exp_empty;
    logic [3:0]  exp_valid;
  } ring_vec_t;

  typedef struct {
    logic [95:0] vals;
    logic [3:0]  ack0, ack1, ack2, ack3;
  } red_vec_t;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pack4(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] c, input logic [23:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [23:0] model_reduce(input logic [95:0] vals);
    longint s;
    logic [23:0] v;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      v = vals[k*24 +: 24];
      s += v[23] ? longint'(v) - 64'sd16777216 : longint'(v);
    end
    if (s > 64'sd8388607) s = 64'sd8388607;
    else if (s < -64'sd8388608) s = -64'sd8388608;
    return s[23:0];
  endfunction

  // One ring-mode cycle: scoreboard pops (checked before the edge) then pushes.
  task automatic ring_step(input logic [3:0] wr, input logic [3:0] rd, input logic [95:0] bus);
    int src;
    logic [23:0] exp_d;
    fifo_wr = wr;
    fifo_rd = rd;
    sum_out = bus;
    for (int j = 0; j < 4; j++) begin
      if (rd[j]) begin
        src = (j + 3) % 4;
        chk("ring_valid", 96'(sum_valid[j]), 96'(sb_q[src].size() != 0));
        if (sb_q[src].size() != 0) begin
          exp_d = sb_q[src].pop_front();
          chk("ring_data", 96'(sum_in[j*24 +: 24]), 96'(exp_d));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (wr[k] && sb_q[k].size() < 8) sb_q[k].push_back(bus[k*24 +: 24]);
    end
    step();
    fifo_wr = '0;
    fifo_rd = '0;
  endtask

  task automatic run_reduce(input red_vec_t v);
    logic [23:0] exp_r;
    logic [3:0]  remain;
    logic [3:0]  acks [4];
    acks[0] = v.ack0; acks[1] = v.ack1; acks[2] = v.ack2; acks[3] = v.ack3;
    fifo_wr = 4'hF;
    sum_out = v.vals;
    step();
    fifo_wr = 4'h0;
    mode    = 1'b1;
    start   = 1'b1;
    res_q.push_back(model_reduce(v.vals));
    step();
    start = 1'b0;
    mode  = 1'b0;
    chk("gather_valid", 96'(sum_valid), 96'(4'h0));
    step();
    chk("result_valid", 96'(sum_valid), 96'(4'hF));
    chk("result_empty", 96'(link_empty), 96'(4'hF));
    exp_r = res_q.pop_front();
    for (int j = 0; j < 4; j++) chk("result_data", 96'(sum_in[j*24 +: 24]), 96'(exp_r));
    remain = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (acks[k] != 4'h0) begin
        fifo_rd = acks[k];
        step();
        fifo_rd = 4'h0;
        remain  = remain & ~acks[k];
        chk("ack_valid", 96'(sum_valid), 96'(remain));
        chk("ack_done", 96'(done), 96'(remain == 4'h0));
      end
    end
    step();
    chk("done_pulse_end", 96'(done), 96'(1'b0));
  endtask

  ring_vec_t ring_tbl [8];
  red_vec_t  red_tbl  [3];

  initial begin
    ring_tbl[0] = '{4'b0001, 4'b0000, 24'h000123, 4'b1110, 4'b0010};
    ring_tbl[1] = '{4'b0000, 4'b0010, 24'h000000, 4'b1111, 4'b0000};
    ring_tbl[2] = '{4'b1111, 4'b0000, 24'h000A00, 4'b0000, 4'b1111};
    ring_tbl[3] = '{4'b0000, 4'b0001, 24'h000000, 4'b1000, 4'b1110};
    ring_tbl[4] = '{4'b0101, 4'b1110, 24'h7FFF00, 4'b1010, 4'b1010};
    ring_tbl[5] = '{4'b0000, 4'b1111, 24'h000000, 4'b1111, 4'b0000};
    ring_tbl[6] = '{4'b1000, 4'b0001, 24'hFFFFFF, 4'b0111, 4'b0001};
    ring_tbl[7] = '{4'b0000, 4'b0001, 24'h000000, 4'b1111, 4'b0000};

    red_tbl[0] = '{pack4(24'd10, 24'hFFFFFD, 24'd100, 24'd7), 4'b1000, 4'b0001, 4'b0100, 4'b0010};
    red_tbl[1] = '{pack4(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF), 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    red_tbl[2] = '{pack4(24'h800000, 24'h800000, 24'h800000, 24'h800000), 4'b0011, 4'b1100, 4'b0000, 4'b0000};

    reset = 1'b1; sum_out = '0; fifo_wr = '0; fifo_rd = '0; mode = 1'b0; start = 1'b0;
    sum_out2 = '0; fifo_wr2 = '0; fifo_rd2 = '0; mode2 = 1'b0; start2 = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_sum_in", sum_in, 96'h0);
    chk("rst_valid", 96'(sum_valid), 96'(4'h0));
    chk("rst_empty", 96'(link_empty), 96'(4'hF));
    chk("rst_full", 96'(link_full), 96'(4'h0));
    chk("rst_ovf", 96'(overflow), 96'(4'h0));
    chk("rst_done", 96'(done), 96'(1'b0));
    chk("rst_empty2", 96'(link_empty2), 96'(2'b11));

    // Ring-pass vectors
    for (int i = 0; i < 8; i++) begin
      ring_step(ring_tbl[i].wr, ring_tbl[i].rd,
                pack4(ring_tbl[i].base, ring_tbl[i].base + 24'h010000,
                      ring_tbl[i].base + 24'h020000, ring_tbl[i].base + 24'h030000));
      chk("vec_empty", 96'(link_empty), 96'(ring_tbl[i].exp_empty));
      chk("vec_valid", 96'(sum_valid), 96'(ring_tbl[i].exp_valid));
    end

    // Link 2 fill past depth, then write+pop on full, then drain in order
    for (int k = 0; k < 9; k++) begin
      ring_step(4'b0100, 4'b0000, pack4(24'h0, 24'h0, 24'h200000 + 24'(k), 24'h0));
      chk("fill_full", 96'(link_full[2]), 96'(sb_q[2].size() == 8));
      chk("fill_ovf", 96'(overflow[2]), 96'(k == 8));
    end
    ring_step(4'b0100, 4'b1000, pack4(24'h0, 24'h0, 24'h2000AA, 24'h0));
    chk("wr_rd_full", 96'(link_full[2]), 96'(1'b1));
    for (int k = 0; k < 8; k++) ring_step(4'b0000, 4'b1000, 96'h0);
    chk("drain_empty", 96'(link_empty[2]), 96'(1'b1));
    chk("ovf_sticky", 96'(overflow), 96'(4'b0100));

    // All-reduce vectors (ordered acks, simultaneous acks, saturation both ways)
    for (int i = 0; i < 3; i++) run_reduce(red_tbl[i]);

    // Gather stalls until every link holds a value
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0; mode = 1'b0;
    fifo_wr = 4'b0111; sum_out = pack4(24'd1, 24'd2, 24'd3, 24'd0);
    step();
    fifo_wr = 4'b0000;
    chk("stall_valid", 96'(sum_valid), 96'(4'h0));
    chk("stall_empty", 96'(link_empty), 96'(4'b1000));
    step();
    chk("stall_empty2", 96'(link_empty), 96'(4'b1000));
    fifo_wr = 4'b1000; sum_out = pack4(24'd0, 24'd0, 24'd0, 24'd4);
    step();
    fifo_wr = 4'b0000;
    chk("last_push_valid", 96'(sum_valid), 96'(4'h0));
    chk("last_push_empty", 96'(link_empty), 96'(4'h0));
    step();
    chk("stall_res_valid", 96'(sum_valid), 96'(4'hF));
    chk("stall_res_data", 96'(sum_in[23:0]), 96'(model_reduce(pack4(24'd1, 24'd2, 24'd3, 24'd4))));

    // Reset while the result is still outstanding
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 96'(sum_valid), 96'(4'h0));
    chk("mid_rst_empty", 96'(link_empty), 96'(4'hF));
    chk("mid_rst_ovf", 96'(overflow), 96'(4'h0));
    chk("mid_rst_done", 96'(done), 96'(1'b0));
    chk("mid_rst_sum_in", sum_in, 96'h0);
    for (int k = 0; k < 4; k++) sb_q[k].delete();
    ring_step(4'b0001, 4'b0000, pack4(24'h0ABCDE, 24'h0, 24'h0, 24'h0));
    chk("post_rst_ring", 96'(sum_valid), 96'(4'b0010));
    ring_step(4'b0000, 4'b0010, 96'h0);

    // Two-core swap
    fifo_wr2 = 2'b11; sum_out2 = {24'hBBBBBB, 24'hAAAAAA};
    step();
    fifo_wr2 = 2'b00;
    chk("swap_valid", 96'(sum_valid2), 96'(2'b11));
    chk("swap_to_core0", 96'(sum_in2[23:0]), 96'(24'hBBBBBB));
    chk("swap_to_core1", 96'(sum_in2[47:24]), 96'(24'hAAAAAA));
    fifo_rd2 = 2'b11;
    step();
    fifo_rd2 = 2'b00;
    chk("swap_empty", 96'(link_empty2), 96'(2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
